down_timer: RTL and testbench

Loadable down-counting timer with one-shot/auto-reload expiry, the count-down counterpart of the existing up counter. It sits beside the ALU datapath as a cycle-delay and timeout source. It reuses the `add_sub` block in subtract mode for the decrement and the `register` block for state. A three-state FSM produces a one-cycle `done` pulse on expiry.

---
 rtl/down_timer.sv | 130 +++++++++++++
 tb/tb_down_timer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-cycle done pulse on expiry.
// Optional periodic auto-reload is enabled by defining DOWN_TIMER_RELOAD_EN.
module down_timer #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             abort,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      EXPIRE  = 2'b10,
      ILLEGAL = 2'b11
   } state_t;

   localparam logic [WIDTH-1:0] ZERO_C = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_C  = {{(WIDTH-1){1'b0}}, 1'b1};

   // Adder/subtractor: sub=1 computes a - b as a + ~b + 1.
   function automatic logic [WIDTH-1:0] add_sub(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             sub
   );
      logic [WIDTH-1:0] b_eff;
      b_eff = sub ? ~b : b;
      return a + b_eff + {{(WIDTH-1){1'b0}}, sub};
   endfunction

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] count_r;
   logic [WIDTH-1:0] count_nx_s;
   logic [WIDTH-1:0] dec_s;

   assign dec_s = add_sub(count_r, ONE_C, 1'b1);

`ifdef DOWN_TIMER_RELOAD_EN
   logic [WIDTH-1:0] reload_r;

   // Reload value register, captured on every load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         reload_r <= ZERO_C;
      end else if (load) begin
         reload_r <= load_value;
      end else begin
         reload_r <= reload_r;
      end
   end
`endif

   // State and count registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         count_r <= ZERO_C;
      end else begin
         state_r <= state_nx_s;
         count_r <= count_nx_s;
      end
   end

   // Next-state and next-count logic; load outranks abort, abort outranks enable.
   always_comb begin
      state_nx_s = state_r;
      count_nx_s = count_r;
      if (load) begin
         count_nx_s = load_value;
         state_nx_s = (load_value != ZERO_C) ? RUN : EXPIRE;
      end else begin
         case (state_r)
            IDLE: begin
               state_nx_s = IDLE;
            end
            RUN: begin
               if (abort) begin
                  state_nx_s = IDLE;
               end else if (enable) begin
                  count_nx_s = dec_s;
                  state_nx_s = (count_r > ONE_C) ? RUN : EXPIRE;
               end else begin
                  state_nx_s = RUN;
               end
            end
            EXPIRE: begin
               if (abort) begin
                  state_nx_s = IDLE;
                  count_nx_s = ZERO_C;
               end else begin
`ifdef DOWN_TIMER_RELOAD_EN
                  // A zero reload would hold done high forever, so stop instead.
                  if (reload_r != ZERO_C) begin
                     state_nx_s = RUN;
                     count_nx_s = reload_r;
                  end else begin
                     state_nx_s = IDLE;
                     count_nx_s = ZERO_C;
                  end
`else
                  state_nx_s = IDLE;
                  count_nx_s = ZERO_C;
`endif
               end
            end
            ILLEGAL: begin
               state_nx_s = IDLE;
            end
            default: begin
               state_nx_s = IDLE;
            end
         endcase
      end
   end

   assign count = count_r;
   assign busy  = (state_r == RUN);
   assign done  = (state_r == EXPIRE);
   assign zero  = (count_r == ZERO_C);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer (WIDTH=3); stimulus pushes expectations, a monitor checks them.
module tb_down_timer;

   logic       clk;
   logic       reset;
   logic       load;
   logic [2:0] load_value;
   logic       enable;
   logic       abort;
   logic [2:0] count;
   logic       busy;
   logic       done;
   logic       zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int cnt;
      int bsy;
      int dne;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   down_timer #(.WIDTH(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (load_value),
      .enable     (enable),
      .abort      (abort),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs and queue the outputs expected after the next edge.
   task automatic cyc(input logic ld, input logic [2:0] lv, input logic en, input logic ab,
                      input int ec, input int eb, input int ed);
      exp_t e;
      @(negedge clk);
      load       = ld;
      load_value = lv;
      enable     = en;
      abort      = ab;
      e.cnt = ec;
      e.bsy = eb;
      e.dne = ed;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs shortly after each edge against the queue head.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         check("count", int'(count), mon_e.cnt);
         check("busy",  int'(busy),  mon_e.bsy);
         check("done",  int'(done),  mon_e.dne);
         check("zero",  int'(zero),  (mon_e.cnt == 0) ? 1 : 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; load = 1'b0; load_value = 3'd0; enable = 1'b0; abort = 1'b0;
      #1;
      check("rst_count", int'(count), 0);
      check("rst_busy",  int'(busy),  0);
      check("rst_done",  int'(done),  0);
      check("rst_zero",  int'(zero),  1);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);

      // One-shot, N=5
      cyc(1'b1, 3'd5, 1'b1, 1'b0, 5, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 4, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 1, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
`ifdef DOWN_TIMER_RELOAD_EN
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 5, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 5, 0, 0);
`else
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
`endif

      // Pause for two cycles at count 2
      cyc(1'b1, 3'd4, 1'b1, 1'b0, 4, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b0, 1'b0, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 1, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 0, 0, 0);

      // Abort at count 3, then load beating abort
      cyc(1'b1, 3'd5, 1'b1, 1'b0, 5, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 4, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 3, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 0, 0);
      cyc(1'b1, 3'd2, 1'b1, 1'b1, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 1, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 0, 0, 0);

      // N=0 expires right after the load edge
      cyc(1'b1, 3'd0, 1'b1, 1'b0, 0, 0, 1);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);

      // N=7 (max), then load during the done cycle
      cyc(1'b1, 3'd7, 1'b1, 1'b0, 7, 1, 0);
      for (int i = 6; i >= 1; i--) cyc(1'b0, 3'd0, 1'b1, 1'b0, i, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
      cyc(1'b1, 3'd2, 1'b1, 1'b0, 2, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 1, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 0, 0, 0);

`ifdef DOWN_TIMER_RELOAD_EN
      // Periodic reload N=3: done every 4 cycles, abort in EXPIRE stops it
      cyc(1'b1, 3'd3, 1'b1, 1'b0, 3, 1, 0);
      for (int p = 0; p < 2; p++) begin
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 2, 1, 0);
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 1, 1, 0);
         cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 1);
         if (p == 0) cyc(1'b0, 3'd0, 1'b1, 1'b0, 3, 1, 0);
      end
      cyc(1'b0, 3'd0, 1'b1, 1'b1, 0, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
`endif

      // Mid-run asynchronous reset at count 4
      cyc(1'b1, 3'd6, 1'b1, 1'b0, 6, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 5, 1, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 4, 1, 0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("mid_rst_count", int'(count), 0);
      check("mid_rst_busy",  int'(busy),  0);
      check("mid_rst_done",  int'(done),  0);
      check("mid_rst_zero",  int'(zero),  1);
      @(negedge clk);
      reset = 1'b0;
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);
      cyc(1'b0, 3'd0, 1'b1, 1'b0, 0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
